// File: rtl/miss_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : miss_refill_ctrl
// Description : Read-miss line refill controller for a 2-way set-associative
//               cache. Fetches one line word-by-word from a 1-cycle-latency
//               backing RAM, writes each word into the selected way's data
//               array and returns the requested word with a done pulse.
//               Optional build macro CRITICAL_WORD_FIRST_EN: fetch starts at
//               the requested offset and wraps; otherwise fetch starts at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module miss_refill_ctrl #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32,
  parameter int OWIDTH = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              miss_req,
  input  logic [AWIDTH-1:0] miss_addr,
  input  logic              miss_way,
  output logic              busy,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DWIDTH-1:0] mem_dout,
  output logic              fill_we,
  output logic              fill_way,
  output logic [AWIDTH-1:0] fill_addr,
  output logic [DWIDTH-1:0] fill_data,
  output logic              done,
  output logic [DWIDTH-1:0] rd_data
);

  localparam int                c_idx_w    = AWIDTH - OWIDTH;
  localparam logic [OWIDTH-1:0] c_last_cnt = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [c_idx_w-1:0]  r_idx;
  logic [OWIDTH-1:0]   r_req_off;
  logic [OWIDTH-1:0]   r_off_cnt;
  logic [OWIDTH-1:0]   r_word_cnt;
  logic [OWIDTH-1:0]   r_fill_off;
  logic                r_way;
  logic                r_fill_we;
  logic [DWIDTH-1:0]   r_rd_data;

  logic [OWIDTH-1:0]   w_start_off;
  logic                w_accept;
  logic                w_last_issue;

`ifdef CRITICAL_WORD_FIRST_EN
  assign w_start_off = miss_addr[OWIDTH-1:0];
`else
  assign w_start_off = '0;
`endif

  assign w_accept     = (r_state == S_IDLE) && miss_req;
  assign w_last_issue = (r_state == S_FETCH) && (r_word_cnt == c_last_cnt);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: FETCH lasts exactly one line of issue cycles, DRAIN
  // absorbs the final returning word, DONE is a single-cycle pulse
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (miss_req)     w_state_next = S_FETCH;
      S_FETCH: if (w_last_issue) w_state_next = S_DRAIN;
      S_DRAIN:                   w_state_next = S_DONE;
      S_DONE:                    w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  // Request capture, offset/word counters, fill pipeline and rd_data capture.
  // The offset counter is frozen on the last issue so mem_addr stays stable
  // outside FETCH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx      <= '0;
      r_req_off  <= '0;
      r_off_cnt  <= '0;
      r_word_cnt <= '0;
      r_fill_off <= '0;
      r_way      <= 1'b0;
      r_fill_we  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_fill_we <= (r_state == S_FETCH);
      if (r_state == S_FETCH) begin
        r_fill_off <= r_off_cnt;
      end
      if (w_accept) begin
        r_idx      <= miss_addr[AWIDTH-1:OWIDTH];
        r_req_off  <= miss_addr[OWIDTH-1:0];
        r_way      <= miss_way;
        r_off_cnt  <= w_start_off;
        r_word_cnt <= '0;
      end else if ((r_state == S_FETCH) && !w_last_issue) begin
        r_off_cnt  <= r_off_cnt + OWIDTH'(1);
        r_word_cnt <= r_word_cnt + OWIDTH'(1);
      end
      if (r_fill_we && (r_fill_off == r_req_off)) begin
        r_rd_data <= mem_dout;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign mem_re    = (r_state == S_FETCH);
  assign mem_addr  = {r_idx, r_off_cnt};
  assign fill_we   = r_fill_we;
  assign fill_way  = r_way;
  assign fill_addr = {r_idx, r_fill_off};
  assign fill_data = mem_dout;
  assign done      = (r_state == S_DONE);
  assign rd_data   = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_miss_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_miss_refill_ctrl
// Description : Self-checking bench for miss_refill_ctrl. Two instances
//               (OWIDTH=1 and OWIDTH=2) share clock and reset; each has its
//               own backing RAM read port model. Expected fetch order, fill
//               writes, done timing and rd_data come from a line-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_miss_refill_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  always #5 clock = ~clock;

  logic        miss_req_v  [2];
  logic [2:0]  miss_addr_v [2];
  logic        miss_way_v  [2];
  logic        busy_v      [2];
  logic [2:0]  mem_addr_v  [2];
  logic        mem_re_v    [2];
  logic [31:0] mem_dout_v  [2];
  logic        fill_we_v   [2];
  logic        fill_way_v  [2];
  logic [2:0]  fill_addr_v [2];
  logic [31:0] fill_data_v [2];
  logic        done_v      [2];
  logic [31:0] rd_data_v   [2];

  logic [31:0] ram [8];
  logic [31:0] exp_rd_hold [2];
  int          n_tests = 0;
  int          n_fail  = 0;

  miss_refill_ctrl #(.AWIDTH(3), .DWIDTH(32), .OWIDTH(1)) u_dut_o1 (
    .clock(clock), .reset_n(reset_n),
    .miss_req(miss_req_v[0]), .miss_addr(miss_addr_v[0]), .miss_way(miss_way_v[0]),
    .busy(busy_v[0]), .mem_addr(mem_addr_v[0]), .mem_re(mem_re_v[0]),
    .mem_dout(mem_dout_v[0]), .fill_we(fill_we_v[0]), .fill_way(fill_way_v[0]),
    .fill_addr(fill_addr_v[0]), .fill_data(fill_data_v[0]),
    .done(done_v[0]), .rd_data(rd_data_v[0])
  );

  miss_refill_ctrl #(.AWIDTH(3), .DWIDTH(32), .OWIDTH(2)) u_dut_o2 (
    .clock(clock), .reset_n(reset_n),
    .miss_req(miss_req_v[1]), .miss_addr(miss_addr_v[1]), .miss_way(miss_way_v[1]),
    .busy(busy_v[1]), .mem_addr(mem_addr_v[1]), .mem_re(mem_re_v[1]),
    .mem_dout(mem_dout_v[1]), .fill_we(fill_we_v[1]), .fill_way(fill_way_v[1]),
    .fill_addr(fill_addr_v[1]), .fill_data(fill_data_v[1]),
    .done(done_v[1]), .rd_data(rd_data_v[1])
  );

  // Backing RAM read ports: address in cycle N, data in cycle N+1
  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_re_v[d]) mem_dout_v[d] <= ram[mem_addr_v[d]];
    end
  end

  // Address of the j-th word fetched for a miss on addr, line of 'words' words
  function automatic logic [2:0] line_addr(input logic [2:0] addr, input int words, input int j);
    int start;
`ifdef CRITICAL_WORD_FIRST_EN
    start = int'(addr) % words;
`else
    start = 0;
`endif
    return 3'((int'(addr) / words) * words + (start + j) % words);
  endfunction

  // One complete refill on instance d; hold keeps miss_req asserted with
  // hold_addr for the whole refill to show it is ignored while busy.
  task automatic do_miss(input int d, input logic [2:0] addr, input logic way,
                         input bit hold, input logic [2:0] hold_addr);
    int          words;
    logic [2:0]  ea;
    words = (d == 0) ? 2 : 4;
    @(negedge clock);
    n_tests++;
    if (busy_v[d] !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy d%0d: got %0b expected 0", d, busy_v[d]);
    end
    n_tests++;
    if (rd_data_v[d] !== exp_rd_hold[d]) begin
      n_fail++; $display("FAIL rd_hold d%0d: got %0h expected %0h", d, rd_data_v[d], exp_rd_hold[d]);
    end
    miss_req_v[d] = 1'b1; miss_addr_v[d] = addr; miss_way_v[d] = way;
    @(posedge clock);
    for (int k = 1; k <= words + 2; k++) begin
      @(negedge clock);
      n_tests++;
      if (busy_v[d] !== 1'b1) begin
        n_fail++; $display("FAIL busy d%0d k%0d: got %0b expected 1", d, k, busy_v[d]);
      end
      n_tests++;
      if (mem_re_v[d] !== (k <= words)) begin
        n_fail++; $display("FAIL mem_re d%0d k%0d: got %0b expected %0b", d, k, mem_re_v[d], (k <= words));
      end
      if (k <= words) begin
        ea = line_addr(addr, words, k - 1);
        n_tests++;
        if (mem_addr_v[d] !== ea) begin
          n_fail++; $display("FAIL mem_addr d%0d k%0d: got %0d expected %0d", d, k, mem_addr_v[d], ea);
        end
      end
      n_tests++;
      if (fill_we_v[d] !== (k >= 2 && k <= words + 1)) begin
        n_fail++; $display("FAIL fill_we d%0d k%0d: got %0b expected %0b", d, k, fill_we_v[d], (k >= 2 && k <= words + 1));
      end
      if (k >= 2 && k <= words + 1) begin
        ea = line_addr(addr, words, k - 2);
        n_tests++;
        if (fill_addr_v[d] !== ea || fill_data_v[d] !== ram[ea] || fill_way_v[d] !== way) begin
          n_fail++;
          $display("FAIL fill d%0d k%0d: got (w%0b,%0d,%0h) expected (w%0b,%0d,%0h)",
                   d, k, fill_way_v[d], fill_addr_v[d], fill_data_v[d], way, ea, ram[ea]);
        end
      end
      n_tests++;
      if (done_v[d] !== (k == words + 2)) begin
        n_fail++; $display("FAIL done d%0d k%0d: got %0b expected %0b", d, k, done_v[d], (k == words + 2));
      end
      if (k == words + 2) begin
        exp_rd_hold[d] = ram[addr];
        n_tests++;
        if (rd_data_v[d] !== ram[addr]) begin
          n_fail++; $display("FAIL rd_data d%0d: got %0h expected %0h", d, rd_data_v[d], ram[addr]);
        end
      end
      if (k == 1) begin
        miss_req_v[d]  = hold;
        miss_addr_v[d] = hold ? hold_addr : 3'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    for (int p = 0; p < 2; p++) begin
      @(negedge clock);
      if (p == 1) begin
        reset_n = 1'b1;
        @(negedge clock);
      end
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if ({busy_v[d], mem_re_v[d], fill_we_v[d], done_v[d]} !== 4'b0 ||
            mem_addr_v[d] !== 3'd0 || fill_addr_v[d] !== 3'd0 || rd_data_v[d] !== 32'd0) begin
          n_fail++;
          $display("FAIL reset_state d%0d p%0d: got b%0b re%0b we%0b dn%0b ma%0d fa%0d rd%0h expected all 0",
                   d, p, busy_v[d], mem_re_v[d], fill_we_v[d], done_v[d], mem_addr_v[d], fill_addr_v[d], rd_data_v[d]);
        end
      end
    end
  endtask

  task automatic test_spec_miss();
    do_miss(0, 3'd5, 1'b1, 1'b0, 3'd0);
    do_miss(1, 3'd7, 1'b0, 1'b0, 3'd0);
    do_miss(1, 3'd2, 1'b1, 1'b0, 3'd0);
  endtask

  task automatic test_back_to_back();
    do_miss(0, 3'd5, 1'b1, 1'b1, 3'd2);
    do_miss(0, 3'd2, 1'b1, 1'b0, 3'd0);
  endtask

  task automatic test_reset_mid_refill();
    @(negedge clock);
    miss_req_v[0] = 1'b1; miss_addr_v[0] = 3'd5; miss_way_v[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    miss_req_v[0] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    n_tests++;
    if (fill_we_v[0] !== 1'b1 || mem_re_v[0] !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset d0: got we%0b re%0b expected we1 re1", fill_we_v[0], mem_re_v[0]);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (busy_v[0] !== 1'b0 || fill_we_v[0] !== 1'b0 || mem_re_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL async_reset d0: got b%0b we%0b re%0b expected 0 0 0", busy_v[0], fill_we_v[0], mem_re_v[0]);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (c == 1) reset_n = 1'b1;
      n_tests++;
      if (done_v[0] !== 1'b0 || fill_we_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
        n_fail++; $display("FAIL post_reset d0 c%0d: got dn%0b we%0b b%0b expected 0 0 0", c, done_v[0], fill_we_v[0], busy_v[0]);
      end
    end
    exp_rd_hold[0] = 32'd0;
    exp_rd_hold[1] = 32'd0;
    do_miss(0, 3'd0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) ram[i] = $urandom;
    for (int it = 0; it < 16; it++) begin
      for (int d = 0; d < 2; d++) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge clock);
        do_miss(d, 3'($urandom), 1'($urandom), 1'b0, 3'd0);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      miss_req_v[d] = 1'b0; miss_addr_v[d] = 3'd0; miss_way_v[d] = 1'b0;
      exp_rd_hold[d] = 32'd0;
    end
    for (int i = 0; i < 8; i++) ram[i] = 32'h100 + i;
    test_reset();
    test_spec_miss();
    test_back_to_back();
    test_reset_mid_refill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
